// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - single-entry instruction fetch stage with redirect, misalign fault and optional static prediction
//
// Purpose:
//   Holds the program counter, reads a combinational instruction ROM and
//   presents one fetched entry at a time to decode through a valid/ready
//   handshake. Execute-stage redirects override everything and restart
//   fetch at the redirect target; a misaligned target yields a single
//   fault entry instead of an instruction, after which fetch stays idle
//   until the next redirect.
//
// Parameters:
//   RESET_PC      - first fetch address after reset
//
// Optional feature macro:
//   FETCH_PRED_EN - when defined, fetch predicts JAL and backward B-type
//                   branches taken and follows their targets; when not
//                   defined, fetch is strictly sequential and
//                   id_pred_taken is constant 0
//
// Ports:
//   clk           in   1  clock, all state on the rising edge
//   rst_n         in   1  asynchronous active-low reset
//   rom_addr      out 32  fetch address to the ROM (equals pc)
//   rom_ins       in  32  ROM data for rom_addr, same cycle
//   id_valid      out  1  id_* fields hold an entry
//   id_ready      in   1  decode accepts the entry this cycle
//   id_ins        out 32  fetched instruction (nop for a fault entry)
//   id_pc         out 32  address of id_ins
//   id_pred_taken out  1  fetch followed a predicted-taken target
//   id_misalign   out  1  entry is a misaligned-fetch fault
//   redirect      in   1  execute-stage redirect request
//   redirect_pc   in  32  redirect target

module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_ins,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_ins,
    output logic [31:0] id_pc,
    output logic        id_pred_taken,
    output logic        id_misalign,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [31:0] NOP_INS = 32'h0000_0013;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_ins_q, id_ins_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic        id_pred_taken_q, id_pred_taken_d;
    logic        id_misalign_q, id_misalign_d;
    // Set once the single fault entry has been produced so FAULT does not
    // emit a second one after decode accepts it.
    logic        fault_sent_q, fault_sent_d;

    logic        accept;
    logic [31:0] seq_pc;
    logic [31:0] next_pc;
    logic        pred_taken;

    assign accept = !id_valid_q || id_ready;
    assign seq_pc = pc_q + 32'd4;

`ifdef FETCH_PRED_EN
    logic [31:0] j_imm;
    logic [31:0] b_imm;
    logic        is_jal;
    logic        is_bwd_branch;

    assign j_imm = {{11{rom_ins[31]}}, rom_ins[31], rom_ins[19:12],
                    rom_ins[20], rom_ins[30:21], 1'b0};
    assign b_imm = {{19{rom_ins[31]}}, rom_ins[31], rom_ins[7],
                    rom_ins[30:25], rom_ins[11:8], 1'b0};

    assign is_jal        = (rom_ins[6:0] == 7'b1101111);
    // Only backward conditional branches are assumed taken (loop closers).
    assign is_bwd_branch = (rom_ins[6:0] == 7'b1100011) && rom_ins[31];

    always_comb begin
        next_pc    = seq_pc;
        pred_taken = 1'b0;
        if (is_jal) begin
            next_pc    = pc_q + j_imm;
            pred_taken = 1'b1;
        end else if (is_bwd_branch) begin
            next_pc    = pc_q + b_imm;
            pred_taken = 1'b1;
        end
    end
`else
    assign next_pc    = seq_pc;
    assign pred_taken = 1'b0;
`endif

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        id_valid_d      = id_valid_q;
        id_ins_d        = id_ins_q;
        id_pc_d         = id_pc_q;
        id_pred_taken_d = id_pred_taken_q;
        id_misalign_d   = id_misalign_q;
        fault_sent_d    = fault_sent_q;

        if (redirect) begin
            // Redirect squashes whatever is held, in any state.
            id_valid_d   = 1'b0;
            pc_d         = redirect_pc;
            fault_sent_d = 1'b0;
            state_d      = (redirect_pc[1:0] != 2'b00) ? ST_FAULT : ST_FETCH;
        end else begin
            unique case (state_q)
                ST_BOOT: begin
                    state_d = ST_FETCH;
                end
                ST_FETCH: begin
                    if (accept) begin
                        id_valid_d      = 1'b1;
                        id_ins_d        = rom_ins;
                        id_pc_d         = pc_q;
                        id_pred_taken_d = pred_taken;
                        id_misalign_d   = 1'b0;
                        pc_d            = next_pc;
                    end
                end
                ST_FAULT: begin
                    if (accept) begin
                        if (!fault_sent_q) begin
                            id_valid_d      = 1'b1;
                            id_ins_d        = NOP_INS;
                            id_pc_d         = pc_q;
                            id_pred_taken_d = 1'b0;
                            id_misalign_d   = 1'b1;
                            fault_sent_d    = 1'b1;
                        end else begin
                            // Fault entry consumed: stay idle until redirect.
                            id_valid_d = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d    = ST_BOOT;
                    id_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_BOOT;
            pc_q            <= RESET_PC;
            id_valid_q      <= 1'b0;
            id_ins_q        <= 32'h0000_0000;
            id_pc_q         <= 32'h0000_0000;
            id_pred_taken_q <= 1'b0;
            id_misalign_q   <= 1'b0;
            fault_sent_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            id_valid_q      <= id_valid_d;
            id_ins_q        <= id_ins_d;
            id_pc_q         <= id_pc_d;
            id_pred_taken_q <= id_pred_taken_d;
            id_misalign_q   <= id_misalign_d;
            fault_sent_q    <= fault_sent_d;
        end
    end

    assign rom_addr      = pc_q;
    assign id_valid      = id_valid_q;
    assign id_ins        = id_ins_q;
    assign id_pc         = id_pc_q;
    assign id_pred_taken = id_pred_taken_q;
    assign id_misalign   = id_misalign_q;

endmodule
